// File: rtl/mux_nto1_stream.sv
// N-channel valid/ready stream multiplexer with a registered output beat.
// MODE 0 uses a loaded select, MODE 1 round-robins among valid channels.
module mux_nto1_stream #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic [N_CH-1:0]          valid_in,
  output logic [N_CH-1:0]          ready_out,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     sel_load_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [SEL_W-1:0]         cur_sel_out,
  output logic                     err_out
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [SEL_W-1:0]  r_cur_sel;
  logic              r_err;

  logic              w_can_take;
  logic [N_CH-1:0]   w_hit;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_valid;
  logic              w_accept;
  logic              w_sel_ok;
  logic [2*N_CH-1:0] w_dbl;
  logic              w_found;
  logic [SEL_W-1:0]  w_next;
  int                w_idx;

  assign w_can_take = !r_valid || ready_in;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    assign w_hit[g]     = (r_cur_sel == SEL_W'(g));
    assign ready_out[g] = rst_n_in && w_can_take && w_hit[g];
  end

  // one-hot select over lanes keeps every index inside N_CH
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_hit[i]) begin
        w_sel_data  = data_in[i*DATA_W +: DATA_W];
        w_sel_valid = valid_in[i];
      end
    end
  end

  assign w_accept = w_sel_valid && w_can_take;
  assign w_sel_ok = int'(sel_in) < N_CH;

  // bit j of the rotated vector is the valid of channel cur_sel+1+j (mod N_CH)
  assign w_dbl = {valid_in, valid_in} >> ((SEL_W+1)'(r_cur_sel) + (SEL_W+1)'(1));

  always_comb begin
    w_found = 1'b0;
    w_next  = r_cur_sel;
    w_idx   = 0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (w_dbl[j]) begin
        w_found = 1'b1;
        w_idx   = int'(r_cur_sel) + 1 + j;
        if (w_idx >= N_CH) w_idx = w_idx - N_CH;
        w_next  = SEL_W'(w_idx);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_cur_sel <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= w_sel_data;
        r_valid <= 1'b1;
      end else if (ready_in) begin
        r_valid <= 1'b0;
      end
      if (MODE == 0) begin
        if (sel_load_in) begin
          if (w_sel_ok) r_cur_sel <= sel_in;
          else          r_err     <= 1'b1;
        end
      end else if ((w_accept || !w_sel_valid) && w_found) begin
        r_cur_sel <= w_next;
      end
    end
  end

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign cur_sel_out = r_cur_sel;
  assign err_out     = r_err;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench: a fixed-select instance (SEL_W=3) and a round-robin instance,
// with per-instance scoreboards checked on every downstream transfer.
module tb_mux_nto1_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        r0n, r1n;
  logic [31:0] din0, din1;
  logic [3:0]  vin0, vin1, rdy0, rdy1;
  logic [2:0]  sel0, cs0;
  logic [1:0]  sel1, cs1;
  logic        ld0, ld1, vout0, vout1, rin0, rin1, err0, err1;
  logic [7:0]  dout0, dout1;

  int ncmp = 0;
  int nfail = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  mux_nto1_stream #(.N_CH(4), .DATA_W(8), .SEL_W(3), .MODE(0)) dut0 (
    .clk_in(clk), .rst_n_in(r0n), .data_in(din0), .valid_in(vin0), .ready_out(rdy0),
    .sel_in(sel0), .sel_load_in(ld0), .data_out(dout0), .valid_out(vout0),
    .ready_in(rin0), .cur_sel_out(cs0), .err_out(err0));

  mux_nto1_stream #(.N_CH(4), .DATA_W(8), .SEL_W(2), .MODE(1)) dut1 (
    .clk_in(clk), .rst_n_in(r1n), .data_in(din1), .valid_in(vin1), .ready_out(rdy1),
    .sel_in(sel1), .sel_load_in(ld1), .data_out(dout1), .valid_out(vout1),
    .ready_in(rin1), .cur_sel_out(cs1), .err_out(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // a transfer happens at this edge when valid_out && ready_in
  always @(posedge clk) begin : mon0
    logic [7:0] e;
    if (r0n && vout0 && rin0) begin
      if (q0.size() == 0) chk("d0_unexpected_beat", {31'd0, vout0}, 32'd0);
      else begin e = q0.pop_front(); chk("d0_beat", dout0, e); end
    end
  end

  always @(posedge clk) begin : mon1
    logic [7:0] e;
    if (r1n && vout1 && rin1) begin
      if (q1.size() == 0) chk("d1_unexpected_beat", {31'd0, vout1}, 32'd0);
      else begin e = q1.pop_front(); chk("d1_beat", dout1, e); end
    end
  end

  initial begin
    r0n = 0; r1n = 0; din0 = '0; din1 = '0; vin0 = '0; vin1 = '0;
    sel0 = '0; sel1 = '0; ld0 = 0; ld1 = 0; rin0 = 0; rin1 = 0;
    repeat (2) nx();
    chk("rst_dout", dout0, 0); chk("rst_vout", vout0, 0); chk("rst_cs", cs0, 0);
    chk("rst_err", err0, 0);   chk("rst_rdy", rdy0, 0);  chk("rst_rdy1", rdy1, 0);

    // MODE 0: select channel 2, stream three beats, other channels busy with junk
    r0n = 1; sel0 = 3'd2; ld0 = 1; rin0 = 1;
    nx(); ld0 = 0;
    chk("sel2_cs", cs0, 2); chk("sel2_rdy", rdy0, 4'b0100);
    din0 = {8'hEE, 8'hA1, 8'hEE, 8'hEE}; vin0 = 4'b1111; q0.push_back(8'hA1);
    nx(); chk("a1_vout", vout0, 1); chk("a1_dout", dout0, 8'hA1);
    din0[23:16] = 8'hA2; q0.push_back(8'hA2);
    nx(); chk("a2_dout", dout0, 8'hA2);
    din0[23:16] = 8'hA3; q0.push_back(8'hA3);
    nx(); chk("a3_dout", dout0, 8'hA3); vin0 = 4'b1011;
    nx(); chk("a_drain_vout", vout0, 0); chk("a_drain_cs", cs0, 2);

    // backpressure
    rin0 = 0; vin0 = 4'b0100; din0[23:16] = 8'hB1; q0.push_back(8'hB1);
    nx(); chk("bp_vout", vout0, 1); chk("bp_dout", dout0, 8'hB1); chk("bp_rdy", rdy0, 0);
    din0[23:16] = 8'hB2; q0.push_back(8'hB2);
    nx(); chk("bp_hold_dout", dout0, 8'hB1); chk("bp_hold_vout", vout0, 1); chk("bp_hold_rdy", rdy0, 0);
    rin0 = 1; #1 chk("bp_release_rdy", rdy0, 4'b0100);
    nx(); chk("b2_dout", dout0, 8'hB2);

    // select load coinciding with an accept: beat still from ch2
    din0[23:16] = 8'hA2; din0[15:8] = 8'h51; vin0 = 4'b0110; sel0 = 3'd1; ld0 = 1;
    q0.push_back(8'hA2); q0.push_back(8'h51);
    nx(); ld0 = 0;
    chk("swap_dout", dout0, 8'hA2); chk("swap_cs", cs0, 1); chk("swap_rdy", rdy0, 4'b0010);
    nx(); chk("ch1_dout", dout0, 8'h51); vin0 = 4'b0000;
    nx(); chk("ch1_drain_vout", vout0, 0);

    // out-of-range select
    sel0 = 3'd5; ld0 = 1;
    nx(); ld0 = 0; chk("oor_cs", cs0, 1); chk("oor_err", err0, 1);
    nx(); nx(); chk("oor_err_sticky", err0, 1);
    sel0 = 3'd0; ld0 = 1;
    nx(); ld0 = 0; chk("reload_cs", cs0, 0); chk("reload_err_sticky", err0, 1);
    chk("d0_queue_empty", q0.size(), 0);
    r0n = 0; #1 chk("d0_rst_err", err0, 0); chk("d0_rst_cs", cs0, 0);

    // MODE 1: fairness with all channels valid
    nx(); r1n = 1; rin1 = 1; din1 = {8'h13, 8'h12, 8'h11, 8'h10}; vin1 = 4'b1111;
    for (int k = 0; k < 5; k++) q1.push_back(8'h10 + 8'(k % 4));
    for (int k = 0; k < 5; k++) begin
      nx(); chk("rr_dout", dout1, 8'h10 + 8'(k % 4));
    end
    vin1 = 4'b0000; chk("rr_cs_after", cs1, 1);
    nx(); chk("rr_drain_vout", vout1, 0);

    // only ch3 and ch0 valid: idle hop to 3, then alternate 3,0
    vin1 = 4'b1000;
    nx(); chk("hop_cs", cs1, 3); chk("hop_vout", vout1, 0);
    vin1 = 4'b1001;
    q1.push_back(8'h13); q1.push_back(8'h10); q1.push_back(8'h13); q1.push_back(8'h10);
    for (int k = 0; k < 4; k++) begin
      nx();
      chk("alt_dout", dout1, (k % 2 == 0) ? 8'h13 : 8'h10);
      chk("alt_cs", cs1, (k % 2 == 0) ? 2'd0 : 2'd3);
    end
    vin1 = 4'b0000;
    nx(); chk("alt_drain_vout", vout1, 0);

    // reset while FULL
    rin1 = 0; vin1 = 4'b1111;
    nx(); chk("full_vout", vout1, 1); chk("full_dout", dout1, 8'h13); chk("full_rdy", rdy1, 0);
    r1n = 0;
    #1 chk("mid_rst_vout", vout1, 0); chk("mid_rst_dout", dout1, 0);
    chk("mid_rst_cs", cs1, 0); chk("mid_rst_rdy", rdy1, 0);
    nx(); r1n = 1; rin1 = 1; q1.push_back(8'h10);
    nx(); chk("post_rst_dout", dout1, 8'h10); chk("post_rst_vout", vout1, 1); chk("mode1_err", err1, 0);
    vin1 = 4'b0000;
    nx(); chk("post_rst_drain", vout1, 0);
    chk("d1_queue_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
